// File: rtl/miss_fill_pkg.sv
// ============================================================================
//  Module   : miss_fill_pkg
//  Brief    : Shared state encoding and address field layout for the
//             cache miss fill controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package miss_fill_pkg;

    localparam int c_TAG_W    = 8;
    localparam int c_IDX_W    = 5;
    localparam int c_WORD_W   = 2;

    localparam int c_TAG_LSB  = 8;
    localparam int c_IDX_LSB  = 3;
    localparam int c_WORD_LSB = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WB    = 3'd1,
        RD    = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rd_ret_pipe.sv
// ============================================================================
//  Module   : rd_ret_pipe
//  Brief    : MEM_LAT-deep valid+word shift register tracking outstanding
//             memory reads until their data returns.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_ret_pipe
    import miss_fill_pkg::*;
#(
    parameter int MEM_LAT = 2
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_vld,
    input  logic [c_WORD_W-1:0] i_word,
    output logic                o_vld,
    output logic [c_WORD_W-1:0] o_word
);

    logic [MEM_LAT-1:0]  r_vld;
    logic [c_WORD_W-1:0] r_word [MEM_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                r_word[i] <= '0;
            end
        end else begin
            r_vld[0]  <= i_vld;
            r_word[0] <= i_word;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_word[i] <= r_word[i-1];
            end
        end
    end

    assign o_vld  = r_vld[MEM_LAT-1];
    assign o_word = r_word[MEM_LAT-1];

endmodule

`default_nettype wire

// File: rtl/miss_fill_ctrl.sv
// ============================================================================
//  Module   : miss_fill_ctrl
//  Brief    : Cache miss handler: optional 4-word writeback of a dirty victim,
//             then a 4-word line fill. Define MISS_FILL_CRIT_WORD_EN to start
//             the fill at the requested (critical) word.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module miss_fill_ctrl
    import miss_fill_pkg::*;
#(
    parameter int MEM_LAT = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        miss,
    input  logic        dirty,
    input  logic [15:0] addr,
    input  logic [7:0]  victim_tag,
    input  logic [15:0] cache_rdata,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  cache_word,
    output logic        cache_wr,
    output logic [15:0] cache_wdata,
    output logic        busy,
    output logic        fill_done
);

    state_t              r_state;
    logic [c_TAG_W-1:0]  r_tag;
    logic [c_TAG_W-1:0]  r_victim_tag;
    logic [c_IDX_W-1:0]  r_index;
    logic [c_WORD_W-1:0] r_crit;
    logic [c_WORD_W-1:0] r_word;
    logic [1:0]          r_beat;
    logic [1:0]          r_ret_cnt;
    logic                r_mem_rd;
    logic                r_mem_wr;
    logic                r_busy;
    logic                r_fill_done;

    logic                w_ret_vld;
    logic [c_WORD_W-1:0] w_ret_word;
    logic [c_WORD_W-1:0] w_start_word;
    logic                w_unused;

`ifdef MISS_FILL_CRIT_WORD_EN
    assign w_start_word = addr[c_WORD_LSB +: c_WORD_W];
`else
    assign w_start_word = '0;
`endif

    // Byte and word-select bits never reach the line address.
    assign w_unused = ^addr[c_IDX_LSB-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_tag        <= '0;
            r_victim_tag <= '0;
            r_index      <= '0;
            r_crit       <= '0;
            r_word       <= '0;
            r_beat       <= '0;
            r_ret_cnt    <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_busy       <= 1'b0;
            r_fill_done  <= 1'b0;
        end else begin
            // Every return is the next of exactly four, so the counter wraps back to 0.
            if (w_ret_vld) begin
                r_ret_cnt <= r_ret_cnt + 2'd1;
            end
            case (r_state)
                IDLE: begin
                    if (miss) begin
                        r_tag        <= addr[c_TAG_LSB +: c_TAG_W];
                        r_index      <= addr[c_IDX_LSB +: c_IDX_W];
                        r_victim_tag <= victim_tag;
                        r_crit       <= w_start_word;
                        r_beat       <= '0;
                        r_busy       <= 1'b1;
                        if (dirty) begin
                            r_state  <= WB;
                            r_word   <= '0;
                            r_mem_wr <= 1'b1;
                        end else begin
                            r_state  <= RD;
                            r_word   <= w_start_word;
                            r_mem_rd <= 1'b1;
                        end
                    end
                end
                WB: begin
                    r_beat <= r_beat + 2'd1;
                    r_word <= r_word + 2'd1;
                    if (r_beat == 2'd3) begin
                        r_state  <= RD;
                        r_word   <= r_crit;
                        r_mem_wr <= 1'b0;
                        r_mem_rd <= 1'b1;
                    end
                end
                RD: begin
                    r_beat <= r_beat + 2'd1;
                    r_word <= r_word + 2'd1;
                    if (r_beat == 2'd3) begin
                        r_state  <= DRAIN;
                        r_mem_rd <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (w_ret_vld && (r_ret_cnt == 2'd3)) begin
                        r_state     <= DONE;
                        r_fill_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_fill_done <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_mem_rd <= 1'b0;
                    r_mem_wr <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    rd_ret_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_rd_ret_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (r_mem_rd),
        .i_word (r_word),
        .o_vld  (w_ret_vld),
        .o_word (w_ret_word)
    );

    assign mem_addr    = {((r_state == WB) ? r_victim_tag : r_tag), r_index, r_word, 1'b0};
    assign mem_rd      = r_mem_rd;
    assign mem_wr      = r_mem_wr;
    assign mem_wdata   = cache_rdata;
    // Writeback reads the cache at the issuing word; fills write at the returning word.
    assign cache_word  = (r_state == WB) ? r_word : w_ret_word;
    assign cache_wr    = w_ret_vld;
    assign cache_wdata = mem_rdata;
    assign busy        = r_busy;
    assign fill_done   = r_fill_done;

endmodule

`default_nettype wire

// File: tb/tb_miss_fill_ctrl.sv
// ============================================================================
//  Module   : tb_miss_fill_ctrl
//  Brief    : Directed self-checking bench for miss_fill_ctrl (MEM_LAT 2 and 4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_miss_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss, miss4, dirty;
    logic [15:0] addr;
    logic [7:0]  victim_tag;
    logic [15:0] cache_rdata, mem_rdata;

    logic [15:0] mem_addr, mem_wdata, cache_wdata;
    logic        mem_rd, mem_wr, cache_wr, busy, fill_done;
    logic [1:0]  cache_word;

    logic        mem_rd4, mem_wr4, busy4, fill_done4;
    logic [15:0] unused_mem_addr4, unused_mem_wdata4, unused_cache_wdata4;
    logic [1:0]  unused_cache_word4;
    logic        unused_cache_wr4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign cache_rdata = 16'hC000 | {14'd0, cache_word};

    miss_fill_ctrl #(.MEM_LAT(2)) dut (
        .clk(clk), .rst(rst), .miss(miss), .dirty(dirty), .addr(addr),
        .victim_tag(victim_tag), .cache_rdata(cache_rdata), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .cache_word(cache_word), .cache_wr(cache_wr), .cache_wdata(cache_wdata),
        .busy(busy), .fill_done(fill_done)
    );

    miss_fill_ctrl #(.MEM_LAT(4)) dut4 (
        .clk(clk), .rst(rst), .miss(miss4), .dirty(1'b0), .addr(16'h12A4),
        .victim_tag(8'h00), .cache_rdata(16'h0000), .mem_rdata(mem_rdata),
        .mem_addr(unused_mem_addr4), .mem_rd(mem_rd4), .mem_wr(mem_wr4),
        .mem_wdata(unused_mem_wdata4), .cache_word(unused_cache_word4),
        .cache_wr(unused_cache_wr4), .cache_wdata(unused_cache_wdata4),
        .busy(busy4), .fill_done(fill_done4)
    );

    // k-th read of the 12A4 fill: critical-word order starts at word 2.
    function automatic logic [1:0] rd_word(int k);
`ifdef MISS_FILL_CRIT_WORD_EN
        return 2'(k + 2);
`else
        return 2'(k);
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b0; miss = 1'b0; miss4 = 1'b0; dirty = 1'b0;
        addr = 16'h0000; victim_tag = 8'h00; mem_rdata = 16'h0000;
        #1;
        n_checks++;
        if ({busy, mem_rd, mem_wr, cache_wr, fill_done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outs got=%b exp=00000", {busy, mem_rd, mem_wr, cache_wr, fill_done});
        end
        n_checks++;
        if ({busy4, mem_rd4, mem_wr4, fill_done4} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_outs4 got=%b exp=0000", {busy4, mem_rd4, mem_wr4, fill_done4});
        end
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, mem_rd, cache_wr} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_idle got=%b exp=000", {busy, mem_rd, cache_wr});
        end
    endtask

    task automatic test_clean_miss();
        logic [1:0] w;
        @(posedge clk); #1 miss = 1'b1; dirty = 1'b0; addr = 16'h12A4; victim_tag = 8'h3C;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1 miss = 1'b0; mem_rdata = 16'hD000 + 16'(c); #1;
            n_checks++;
            if (mem_rd !== (c <= 4) || mem_wr !== 1'b0) begin
                n_fail++;
                $display("FAIL clean_strobe c=%0d rd=%b wr=%b exp_rd=%b", c, mem_rd, mem_wr, (c <= 4));
            end
            if (c <= 4) begin
                w = rd_word(c - 1);
                n_checks++;
                if (mem_addr !== (16'h12A0 | {13'd0, w, 1'b0})) begin
                    n_fail++;
                    $display("FAIL clean_addr c=%0d got=%h exp=%h", c, mem_addr, 16'h12A0 | {13'd0, w, 1'b0});
                end
            end
            n_checks++;
            if (cache_wr !== (c >= 3 && c <= 6)) begin
                n_fail++;
                $display("FAIL clean_cwr c=%0d got=%b exp=%b", c, cache_wr, (c >= 3 && c <= 6));
            end
            if (c >= 3 && c <= 6) begin
                w = rd_word(c - 3);
                n_checks++;
                if (cache_word !== w || cache_wdata !== 16'hD000 + 16'(c)) begin
                    n_fail++;
                    $display("FAIL clean_fill c=%0d word=%0d exp=%0d data=%h exp=%h",
                             c, cache_word, w, cache_wdata, 16'hD000 + 16'(c));
                end
            end
            n_checks++;
            if (fill_done !== (c == 7) || busy !== (c <= 7)) begin
                n_fail++;
                $display("FAIL clean_done c=%0d done=%b busy=%b exp_done=%b exp_busy=%b",
                         c, fill_done, busy, (c == 7), (c <= 7));
            end
        end
    endtask

    task automatic test_dirty_miss();
        logic [1:0] w;
        @(posedge clk); #1 miss = 1'b1; dirty = 1'b1; addr = 16'h12A4; victim_tag = 8'h3C;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1 miss = 1'b0; dirty = 1'b0; mem_rdata = 16'hE000 + 16'(c); #1;
            n_checks++;
            if (mem_wr !== (c <= 4) || mem_rd !== (c >= 5 && c <= 8)) begin
                n_fail++;
                $display("FAIL dirty_strobe c=%0d wr=%b rd=%b", c, mem_wr, mem_rd);
            end
            if (c <= 4) begin
                w = 2'(c - 1);
                n_checks++;
                if (mem_addr !== (16'h3CA0 | {13'd0, w, 1'b0}) || cache_word !== w ||
                    mem_wdata !== (16'hC000 | {14'd0, w})) begin
                    n_fail++;
                    $display("FAIL dirty_wb c=%0d addr=%h word=%0d wdata=%h exp_addr=%h exp_word=%0d",
                             c, mem_addr, cache_word, mem_wdata, 16'h3CA0 | {13'd0, w, 1'b0}, w);
                end
            end
            if (c >= 5 && c <= 8) begin
                w = rd_word(c - 5);
                n_checks++;
                if (mem_addr !== (16'h12A0 | {13'd0, w, 1'b0})) begin
                    n_fail++;
                    $display("FAIL dirty_rdaddr c=%0d got=%h exp=%h", c, mem_addr, 16'h12A0 | {13'd0, w, 1'b0});
                end
            end
            n_checks++;
            if (cache_wr !== (c >= 7 && c <= 10)) begin
                n_fail++;
                $display("FAIL dirty_cwr c=%0d got=%b exp=%b", c, cache_wr, (c >= 7 && c <= 10));
            end
            if (c >= 7 && c <= 10) begin
                w = rd_word(c - 7);
                n_checks++;
                if (cache_word !== w) begin
                    n_fail++;
                    $display("FAIL dirty_cword c=%0d got=%0d exp=%0d", c, cache_word, w);
                end
            end
            n_checks++;
            if (fill_done !== (c == 11) || busy !== (c <= 11)) begin
                n_fail++;
                $display("FAIL dirty_done c=%0d done=%b busy=%b", c, fill_done, busy);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        @(posedge clk); #1 miss = 1'b1; dirty = 1'b0; addr = 16'h12A4;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1 miss = 1'b0;
        end
        rst = 1'b0; #1;
        n_checks++;
        if ({busy, mem_rd, cache_wr, fill_done} !== 4'b0) begin
            n_fail++;
            $display("FAIL midrst_immediate got=%b exp=0000", {busy, mem_rd, cache_wr, fill_done});
        end
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (cache_wr !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_after c=%0d cwr=%b busy=%b rd=%b exp=0", c, cache_wr, busy, mem_rd);
            end
        end
    endtask

    task automatic test_ignore_miss();
        @(posedge clk); #1 miss = 1'b1; dirty = 1'b0; addr = 16'h12A4;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1 miss = (c == 2 || c == 7); #1;
            n_checks++;
            if (fill_done !== (c == 7) || busy !== (c <= 7) || mem_rd !== (c <= 4)) begin
                n_fail++;
                $display("FAIL ignore_miss c=%0d done=%b busy=%b rd=%b exp=%b%b%b",
                         c, fill_done, busy, mem_rd, (c == 7), (c <= 7), (c <= 4));
            end
        end
        miss = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_busy, exp_rd;
        @(posedge clk); #1 miss4 = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1 miss4 = (c < 20); #1;
            exp_busy = (c >= 1 && c <= 9) || (c >= 11 && c <= 19);
            exp_rd   = (c >= 1 && c <= 4) || (c >= 11 && c <= 14);
            n_checks++;
            if (fill_done4 !== (c == 9 || c == 19) || busy4 !== exp_busy ||
                mem_rd4 !== exp_rd || mem_wr4 !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b c=%0d done=%b busy=%b rd=%b wr=%b exp=%b%b%b0",
                         c, fill_done4, busy4, mem_rd4, mem_wr4, (c == 9 || c == 19), exp_busy, exp_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_reset_mid_fill();
        test_ignore_miss();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/miss_fill_ctrl.md
MISS_FILL_CTRL -- requirements
Module: miss_fill_ctrl

Interface
REQ-001 SHALL have one parameter: MEM_LAT, default 2, memory read latency in cycles (legal 1..4).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: miss  input  1  miss request, sampled only in IDLE.
REQ-005 SHALL have port: dirty  input  1  victim line dirty, sampled with miss.
REQ-006 SHALL have port: addr  input  16  miss address; tag [15:8], index [7:3], word [2:1], byte [0].
REQ-007 SHALL have port: victim_tag  input  8  tag of the evicted line, sampled with miss.
REQ-008 SHALL have port: cache_rdata  input  16  cache word at cache_word, combinational read.
REQ-009 SHALL have port: mem_rdata  input  16  memory read data, valid MEM_LAT cycles after mem_rd.
REQ-010 SHALL have port: mem_addr  output  16  memory word address, bit 0 always 0.
REQ-011 SHALL have port: mem_rd / mem_wr  output  1 each  memory read/write strobes, never both high.
REQ-012 SHALL have port: mem_wdata  output  16  writeback data, equal to cache_rdata.
REQ-013 SHALL have port: cache_word  output  2  cache word select.
REQ-014 SHALL have port: cache_wr  output  1  cache fill write strobe.
REQ-015 SHALL have port: cache_wdata  output  16  fill data, equal to mem_rdata.
REQ-016 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port: fill_done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, WB, RD, DRAIN and DONE.
REQ-019 IDLE with miss=1 SHALL latch addr, dirty and victim_tag, then go to WB if dirty, else RD.
REQ-020 WB SHALL last exactly 4 cycles, issuing mem_wr for words 0,1,2,3 with mem_addr={victim_tag,index,word,1'b0} and cache_word=word, then go to RD.
REQ-021 RD SHALL last exactly 4 cycles, issuing one mem_rd per cycle with mem_addr={tag,index,word,1'b0}, then go to DRAIN.
REQ-022 Each read SHALL return MEM_LAT cycles after issue; in that cycle the block SHALL assert cache_wr with cache_word equal to the word issued.
REQ-023 Return tracking SHALL use a MEM_LAT-deep valid+word shift register, so writes overlap issue when MEM_LAT<4.
REQ-024 DRAIN SHALL exit to DONE in the cycle the fourth return is written.
REQ-025 DONE SHALL assert fill_done for exactly 1 cycle, then go to IDLE.
REQ-026 Clean-miss latency: miss accepted at cycle 0, reads at cycles 1-4, fill_done at cycle 5+MEM_LAT; a dirty miss adds exactly 4 cycles.
REQ-027 Word counter SHALL be 2 bits and wrap 3->0 modulo 4.
REQ-028 miss outside IDLE SHALL be ignored, including in DONE; a miss held high SHALL start a new fill on the cycle after DONE.
REQ-029 Outside their active states, mem_rd, mem_wr, cache_wr and fill_done SHALL be 0; mem_addr, cache_word and data outputs are don't-care.

Reset
REQ-030 Asserting rst SHALL immediately force IDLE, clear the return pipeline and drive busy, mem_rd, mem_wr, cache_wr and fill_done to 0.
REQ-031 Reset mid-fill SHALL abandon the fill; after release, no cache_wr for in-flight reads SHALL occur.
REQ-032 All latched registers SHALL reset to 0.

Configuration
REQ-033 With MISS_FILL_CRIT_WORD_EN defined, RD SHALL start at the requested word addr[2:1] and wrap modulo 4 (e.g. 2,3,0,1); WB order is unchanged.
REQ-034 Without MISS_FILL_CRIT_WORD_EN, RD SHALL always issue words 0,1,2,3.

Structure
REQ-035 A shared package miss_fill_pkg SHALL hold the state enum, field widths (tag 8, index 5, word 2) and field-position constants.
REQ-036 The return pipeline SHALL be the sole sub-module: rd_ret_pipe, parameterised by MEM_LAT.

Verification
REQ-037 Clean miss, addr=16'h12A4, MEM_LAT=2 -> mem_rd at cycles 1-4 to 12A0,12A2,12A4,12A6; cache_wr at cycles 3-6; fill_done at cycle 7.
REQ-038 Dirty miss, victim_tag=8'h3C, addr=16'h12A4 -> mem_wr at cycles 1-4 to 3CA0,3CA2,3CA4,3CA6 carrying cache_rdata; reads at cycles 5-8; fill_done at cycle 11.
REQ-039 MISS_FILL_CRIT_WORD_EN defined, addr=16'h12A4 -> read order 12A4,12A6,12A0,12A2 and cache_word order 2,3,0,1.
REQ-040 rst asserted at cycle 3 of a clean fill, then miss=0 -> no cache_wr after reset; busy=0 immediately.
REQ-041 miss held high for 20 cycles, MEM_LAT=4 -> back-to-back fills, each fill_done at cycle 9 relative to its start; miss pulses during busy are ignored.
